// File: rtl/rs_deinterleaver.sv
// rs_deinterleaver: ping-pong buffer that splits one interleaved CVCDU into DEPTH RS codewords
module rs_deinterleaver #(
  parameter int DEPTH = 4,
  parameter int N     = 255
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     new_cvcdu,
  input  logic [7:0]               data_in,
  input  logic                     data_valid_in,
  output logic [7:0]               data_out,
  output logic                     data_valid_out,
  input  logic                     data_ready_in,
  output logic [$clog2(DEPTH)-1:0] cw_index_out,
  output logic                     cw_start_out,
  output logic                     cw_last_out,
  output logic                     frame_done_out,
  output logic                     overflow_out
);
  localparam int FL = DEPTH * N;
  localparam int AW = $clog2(FL + 1);
  localparam int CW = $clog2(DEPTH);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, READ} state_t;
  logic [7:0]    mem [2][FL];
  logic [7:0]    rdata_q;
  state_t        state_q, state_d;
  logic          wr_act_q, wr_act_d, wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0] wcw_q, wcw_d, rcw_q, rcw_d, cw_idx_q, cw_idx_d;
  logic [PW-1:0] wpos_q, wpos_d, rpos_q, rpos_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          ovf_q, ovf_d, vld_q, vld_d, start_q, start_d, last_q, last_d;
  logic          flast_q, flast_d, done_q, done_d;
  logic          we, wend, issue, fdone;
  logic [CW-1:0] wcw;
  logic [PW-1:0] wpos;
  logic [AW-1:0] waddr;
  always_comb begin
    wcw       = new_cvcdu ? '0 : wcw_q;
    wpos      = new_cvcdu ? '0 : wpos_q;
    waddr     = AW'(wcw) * AW'(N) + AW'(wpos);
    wend      = (wcw == CW'(DEPTH - 1)) && (wpos == PW'(N - 1));
    // a new frame may only claim an empty bank; an active bank is never full
    we        = data_valid_in & (new_cvcdu ? ~full_q[wr_bank_q] : wr_act_q);
    ovf_d     = data_valid_in & new_cvcdu & full_q[wr_bank_q];
    wr_act_d  = we ? ~wend : wr_act_q;
    wcw_d     = we ? ((wcw == CW'(DEPTH - 1)) ? '0 : wcw + 1'b1) : wcw_q;
    wpos_d    = we ? wpos + PW'(wcw == CW'(DEPTH - 1)) : wpos_q;
    wr_bank_d = wr_bank_q ^ (we & wend);
    fdone     = vld_q & data_ready_in & flast_q;
    issue     = (state_q == READ) && (raddr_q != AW'(FL)) && (~vld_q || data_ready_in);
    state_d   = (state_q == IDLE) ? (full_q[rd_bank_q] ? READ : IDLE) : (fdone ? IDLE : READ);
    raddr_d   = (state_q == IDLE) ? '0 : raddr_q + AW'(issue);
    rpos_d    = (state_q == IDLE) ? '0 : issue ? ((rpos_q == PW'(N - 1)) ? '0 : rpos_q + 1'b1) : rpos_q;
    rcw_d     = (state_q == IDLE) ? '0 : (issue && rpos_q == PW'(N - 1)) ? rcw_q + 1'b1 : rcw_q;
    vld_d     = issue | (vld_q & ~data_ready_in);
    cw_idx_d  = issue ? rcw_q : cw_idx_q;
    start_d   = issue ? (rpos_q == '0) : start_q;
    last_d    = issue ? (rpos_q == PW'(N - 1)) : last_q;
    flast_d   = issue ? (raddr_q == AW'(FL - 1)) : flast_q;
    done_d    = fdone;
    rd_bank_d = rd_bank_q ^ fdone;
    full_d    = (full_q & ~(2'(fdone) << rd_bank_q)) | (2'(we & wend) << wr_bank_q);
  end
  always_ff @(posedge clk_in) begin
    if (we) mem[wr_bank_q][waddr] <= data_in;
    if (issue) rdata_q <= mem[rd_bank_q][raddr_q];
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      wr_act_q  <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wcw_q     <= '0;
      wpos_q    <= '0;
      rcw_q     <= '0;
      rpos_q    <= '0;
      cw_idx_q  <= '0;
      full_q    <= '0;
      raddr_q   <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      flast_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_act_q  <= wr_act_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wcw_q     <= wcw_d;
      wpos_q    <= wpos_d;
      rcw_q     <= rcw_d;
      rpos_q    <= rpos_d;
      cw_idx_q  <= cw_idx_d;
      full_q    <= full_d;
      raddr_q   <= raddr_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      start_q   <= start_d;
      last_q    <= last_d;
      flast_q   <= flast_d;
      done_q    <= done_d;
    end
  end
  assign data_out       = vld_q ? rdata_q : '0;
  assign data_valid_out = vld_q;
  assign cw_index_out   = cw_idx_q;
  assign cw_start_out   = start_q;
  assign cw_last_out    = last_q;
  assign frame_done_out = done_q;
  assign overflow_out   = ovf_q;
endmodule

// File: tb/tb_rs_deinterleaver.sv
// tb_rs_deinterleaver: directed frames checked against the expected codeword order
module tb_rs_deinterleaver;
  logic       clk_in = 0, rst_in = 0, new_cvcdu = 0, data_valid_in = 0, data_ready_in = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic [1:0] cw_index_out;
  logic       data_valid_out, cw_start_out, cw_last_out, frame_done_out, overflow_out;
  int checks = 0, errors = 0, cyc = 0, wlast = 0, ready_mode = 0;
  int vcnt = 0, ovf_cnt = 0, hold_bad = 0;
  logic [11:0] obs[$];
  int          xq[$];
  int          dq[$];
  logic        stall = 0;
  logic [12:0] hold = 0;
  rs_deinterleaver dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_cvcdu(new_cvcdu), .data_in(data_in),
    .data_valid_in(data_valid_in), .data_out(data_out), .data_valid_out(data_valid_out),
    .data_ready_in(data_ready_in), .cw_index_out(cw_index_out), .cw_start_out(cw_start_out),
    .cw_last_out(cw_last_out), .frame_done_out(frame_done_out), .overflow_out(overflow_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk_in);
    #1;
    data_ready_in = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (stall && hold !== {data_valid_out, data_out, cw_index_out, cw_start_out, cw_last_out})
        hold_bad++;
      if (data_valid_out) vcnt++;
      if (data_valid_out && data_ready_in) begin
        obs.push_back({data_out, cw_index_out, cw_start_out, cw_last_out});
        xq.push_back(cyc);
      end
      if (frame_done_out) dq.push_back(cyc);
      if (overflow_out) ovf_cnt++;
      stall = data_valid_out & ~data_ready_in;
      hold  = {data_valid_out, data_out, cw_index_out, cw_start_out, cw_last_out};
    end else stall = 0;
  end
  function automatic logic [7:0] fb(input int f, input int i);
    return 8'((i + f * 37) % 256);
  endfunction
  function automatic logic [11:0] ent(input int f, input int k);
    int cw, pos;
    cw  = k / 255;
    pos = k % 255;
    return {fb(f, pos * 4 + cw), 2'(cw), pos == 0, pos == 254};
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic nw, input int gap);
    data_valid_in = 1;
    data_in       = d;
    new_cvcdu     = nw;
    wlast         = cyc;
    tick();
    data_valid_in = 0;
    new_cvcdu     = 0;
    repeat (gap) tick();
  endtask
  task automatic send_frame(input int f, input int nb, input int gap);
    for (int i = 0; i < nb; i++) send(fb(f, i), i == 0, gap);
  endtask
  task automatic wait_obs(input int n);
    for (int i = 0; i < 30000 && obs.size() < n; i++) tick();
    repeat (10) tick();
  endtask
  task automatic cmp(input string tag, input int base, input int f0, input int nf);
    chk({tag, "_len"}, obs.size() - base, nf * 1020);
    for (int j = 0; j < nf * 1020 && base + j < obs.size(); j++)
      chk(tag, int'(obs[base + j]), int'(ent(f0 + j / 1020, j % 1020)));
  endtask
  initial begin
    int b, bd, bo, bv, bx, hb;
    logic [11:0] e;
    repeat (3) tick();
    @(negedge clk_in);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_meta", {cw_index_out, cw_start_out, cw_last_out}, 0);
    chk("rst_pulses", {frame_done_out, overflow_out}, 0);
    rst_in = 1;
    tick();
    ready_mode = 1;
    tick();
    b = obs.size(); bd = dq.size(); bv = vcnt; hb = hold_bad;
    send_frame(0, 1020, 3);
    bx = wlast;
    wait_obs(b + 1020);
    cmp("t1", b, 0, 1);
    e = obs[b];        chk("t1_cw0p0", e, {8'd0, 2'd0, 2'b10});
    e = obs[b + 1];    chk("t1_cw0p1", e, {8'd4, 2'd0, 2'b00});
    e = obs[b + 2];    chk("t1_cw0p2", e, {8'd8, 2'd0, 2'b00});
    e = obs[b + 254];  chk("t1_cw0p254", e, {8'd248, 2'd0, 2'b01});
    e = obs[b + 255];  chk("t1_cw1p0", e, {8'd1, 2'd1, 2'b10});
    e = obs[b + 256];  chk("t1_cw1p1", e, {8'd5, 2'd1, 2'b00});
    e = obs[b + 1019]; chk("t1_cw3p254", e, {8'd251, 2'd3, 2'b01});
    chk("t1_latency", xq[b], bx + 3);
    chk("t1_done_cnt", dq.size() - bd, 1);
    chk("t1_done_time", dq[bd], xq[b + 1019] + 1);
    chk("t1_valid_cycles", vcnt - bv, 1020);
    ready_mode = 2;
    b = obs.size();
    send_frame(1, 1020, 0);
    wait_obs(b + 1020);
    cmp("t2", b, 1, 1);
    chk("t2_hold", hold_bad - hb, 0);
    ready_mode = 0;
    repeat (3) tick();
    b = obs.size(); bd = dq.size(); bo = ovf_cnt;
    send_frame(2, 1020, 0);
    send_frame(3, 1020, 0);
    repeat (5) tick();
    chk("t3_no_ovf", ovf_cnt - bo, 0);
    send_frame(4, 1020, 0);
    repeat (5) tick();
    chk("t3_ovf_pulse", ovf_cnt - bo, 1);
    chk("t3_no_out", obs.size() - b, 0);
    ready_mode = 1;
    wait_obs(b + 2040);
    cmp("t3", b, 2, 2);
    chk("t3_done_cnt", dq.size() - bd, 2);
    chk("t3_done_time", dq[bd], xq[b + 1019] + 1);
    chk("t3_next_frame", xq[b + 1020], xq[b + 1019] + 3);
    b = obs.size();
    send_frame(5, 500, 0);
    send_frame(6, 1020, 0);
    wait_obs(b + 1020);
    cmp("t4", b, 6, 1);
    b = obs.size();
    send_frame(7, 1020, 0);
    wait_obs(b + 300);
    for (int i = 0; i < 30000 && obs.size() < b + 300; i++) tick();
    rst_in = 0;
    tick();
    rst_in = 1;
    @(negedge clk_in);
    chk("t5_rst_out", {data_out, data_valid_out, cw_index_out, cw_start_out, cw_last_out,
                       frame_done_out, overflow_out}, 0);
    tick();
    b = obs.size();
    repeat (2100) tick();
    chk("t5_quiet", obs.size() - b, 0);
    send_frame(8, 1020, 0);
    wait_obs(b + 1020);
    cmp("t5", b, 8, 1);
    b = obs.size();
    for (int i = 0; i < 200; i++) send(8'($urandom_range(0, 255)), 0, 0);
    send_frame(9, 1020, 0);
    wait_obs(b + 1020);
    cmp("t6", b, 9, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
